// File: rtl/nap_axi_mem_responder.sv
// AXI4 memory responder terminating NAP read/write bursts in an inferred dual-port RAM.
// Independent write (AW/W/B) and read (AR/R) engines share only the memory and the error counter.
module nap_axi_mem_responder #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 42,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned MEM_DEPTH  = 512
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic [15:0]             o_err_count
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t            w_state, w_next;
    logic [ID_WIDTH-1:0] w_id;
    logic [IDX_W-1:0]    w_idx;
    logic [7:0]          w_len, w_beat;
    logic                w_err, w_nowr;

    r_state_t            r_state, r_next;
    logic [ID_WIDTH-1:0] r_id;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_len, r_beat;
    logic                r_err;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, beat_err;
    logic b_err_evt, r_err_evt;
    logic [16:0] err_sum;

    // Size, burst-size and high address bits carry no meaning for a flat word memory.
    logic unused_bits;
    assign unused_bits = ^{awsize, arsize, awaddr, araddr};

    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign b_hs     = bvalid && bready;
    assign ar_hs    = arvalid && arready;
    assign r_hs     = rvalid && rready;
    assign beat_err = wlast != (w_beat == w_len);

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && wlast) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
            w_nowr  <= 1'b0;
        end else begin
            w_state <= w_next;
            awready <= (w_next == W_IDLE);
            wready  <= (w_next == W_DATA);
            bvalid  <= (w_next == W_RESP);
            if (aw_hs) begin
                w_id   <= awid;
                w_idx  <= awaddr[OFF_W +: IDX_W];
                w_len  <= awlen;
                w_beat <= '0;
                w_err  <= (awburst != BURST_INCR);
                w_nowr <= (awburst != BURST_INCR);
            end
            if (w_hs) begin
                w_idx  <= w_idx + IDX_W'(1);
                w_beat <= w_beat + 8'(1);
                if (beat_err) w_err <= 1'b1;
                if (wlast) begin
                    bid   <= w_id;
                    bresp <= (w_err || beat_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Byte-masked memory write; a burst with an illegal type never touches memory.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_hs && !w_nowr) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_FETCH;
            R_FETCH: r_next = R_DATA;
            R_DATA:  if (r_hs) r_next = rlast ? R_IDLE : R_FETCH;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= r_next;
            arready <= (r_next == R_IDLE);
            rvalid  <= (r_next == R_DATA);
            if (ar_hs) begin
                r_id   <= arid;
                r_idx  <= araddr[OFF_W +: IDX_W];
                r_len  <= arlen;
                r_beat <= '0;
                r_err  <= (arburst != BURST_INCR);
            end
            // Registered memory read; same-cycle writes are not yet visible (read-first).
            if (r_state == R_FETCH) begin
                rdata <= r_err ? '0 : mem[r_idx];
                rid   <= r_id;
                rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
                rlast <= (r_beat == r_len);
            end
            if (r_hs && !rlast) begin
                r_idx  <= r_idx + IDX_W'(1);
                r_beat <= r_beat + 8'(1);
            end
        end
    end

    // One count per failed burst: B handshake, or first beat of an R burst.
    assign b_err_evt = b_hs && (bresp == RESP_SLVERR);
    assign r_err_evt = r_hs && (rresp == RESP_SLVERR) && (r_beat == 8'd0);
    assign err_sum   = 17'(o_err_count) + 17'(b_err_evt) + 17'(r_err_evt);

    always_ff @(posedge i_clk) begin
        if (i_reset) o_err_count <= '0;
        else         o_err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
endmodule

// File: tb/tb_nap_axi_mem_responder.sv
// Self-checking bench: a word-array memory model predicts every B and R beat, checked each cycle.
module tb_nap_axi_mem_responder;
    localparam int unsigned DW = 256;
    localparam int unsigned AW = 42;
    localparam int unsigned IW = 8;
    localparam int unsigned MD = 512;
    localparam int unsigned SW = DW / 8;

    logic clk, i_reset;
    logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic arvalid, arready, rvalid, rready, rlast;
    logic [IW-1:0] awid, bid, arid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [15:0] o_err_count;

    nap_axi_mem_responder dut (
        .i_clk(clk), .i_reset(i_reset),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .o_err_count(o_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; logic first; } rbeat_t;
    typedef struct { logic [IW-1:0] id; logic [1:0] resp; } bresp_t;

    logic [DW-1:0] mdl [MD];
    rbeat_t exp_r[$];
    bresp_t exp_b[$];

    int checks = 0;
    int failures = 0;
    int exp_err = 0;
    int pend = 0;
    int r_beats_seen = 0;
    logic rst_s = 1'b0;
    logic b_hs_prev = 1'b0;
    logic [1:0] ar_hist = 2'b00;
    logic [IW-1:0] last_bid, last_rid;
    logic [1:0] last_bresp;
    logic last_rlast;
    logic [DW-1:0] last_rdata;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int s, input int b);
        if (s < 0) return '1;
        return {(DW/32){32'(s * 256 + b)}};
    endfunction

    always @(posedge clk) rst_s <= i_reset;

    // Per-cycle compare against the model queues.
    always @(negedge clk) begin
        if (rst_s) begin
            chk("rst_ctrl_zero", DW'({awready, wready, bvalid, arready, rvalid, rlast, rresp,
                                      bresp, rid, bid, o_err_count}), '0);
            chk("rst_rdata_zero", rdata, '0);
            exp_r.delete();
            exp_b.delete();
            exp_err = 0; pend = 0; b_hs_prev = 1'b0; ar_hist = 2'b00;
        end else begin
            exp_err = (exp_err + pend > 65535) ? 65535 : exp_err + pend;
            pend = 0;
            chk("err_count", DW'(o_err_count), DW'(exp_err));
            if (b_hs_prev) chk("awready_after_b", DW'(awready), 1);
            if (ar_hist[1]) chk("rvalid_2cyc_after_ar", DW'(rvalid), 1);
            ar_hist = {ar_hist[0], arvalid && arready};
            b_hs_prev = bvalid && bready;
            if (bvalid) begin
                if (exp_b.size() == 0) chk("b_unexpected", DW'(bvalid), 0);
                else begin
                    chk("bid", DW'(bid), DW'(exp_b[0].id));
                    chk("bresp", DW'(bresp), DW'(exp_b[0].resp));
                    if (bready) begin
                        last_bid = bid; last_bresp = bresp;
                        if (exp_b[0].resp == 2'b10) pend++;
                        void'(exp_b.pop_front());
                    end
                end
            end
            if (rvalid) begin
                if (exp_r.size() == 0) chk("r_unexpected", DW'(rvalid), 0);
                else begin
                    chk("rid", DW'(rid), DW'(exp_r[0].id));
                    chk("rdata", rdata, exp_r[0].data);
                    chk("rresp", DW'(rresp), DW'(exp_r[0].resp));
                    chk("rlast", DW'(rlast), DW'(exp_r[0].last));
                    if (rready) begin
                        last_rid = rid; last_rdata = rdata; last_rlast = rlast;
                        r_beats_seen++;
                        if (exp_r[0].first && exp_r[0].resp == 2'b10) pend++;
                        void'(exp_r.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                         input logic [1:0] burst);
        logic got;
        int n = 0;
        awid = id; awaddr = a; awlen = len; awburst = burst; awsize = 3'd5; awvalid = 1'b1;
        do begin @(negedge clk); got = awready; tick(); n++; end while (!got && n < 200);
        awvalid = 1'b0;
        if (!got) chk("aw_timeout", DW'(awready), 1);
    endtask

    task automatic do_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l,
                        input int idx, input bit wr);
        logic got;
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        do begin @(negedge clk); got = wready; tick(); n++; end while (!got && n < 200);
        wvalid = 1'b0; wlast = 1'b0;
        if (!got) chk("w_timeout", DW'(wready), 1);
        else if (wr) for (int b = 0; b < int'(SW); b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic do_ar(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                         input logic [1:0] burst);
        logic got;
        int n = 0;
        arid = id; araddr = a; arlen = len; arburst = burst; arsize = 3'd5; arvalid = 1'b1;
        do begin @(negedge clk); got = arready; tick(); n++; end while (!got && n < 200);
        arvalid = 1'b0;
        if (!got) chk("ar_timeout", DW'(arready), 1);
    endtask

    task automatic wburst(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats, input int seed,
                          input logic [SW-1:0] s);
        int idx = int'(a[5 +: 9]);
        int n = 0;
        do_aw(id, a, len, burst);
        for (int b = 0; b < nbeats; b++) begin
            do_w(pat(seed, b), s, b == nbeats - 1, idx, burst == 2'b01);
            idx = (idx + 1) % MD;
        end
        exp_b.push_back('{id: id, resp: (burst != 2'b01 || nbeats != int'(len) + 1) ? 2'b10 : 2'b00});
        while (exp_b.size() != 0 && n < 200) begin tick(); n++; end
        if (exp_b.size() != 0) chk("b_timeout", DW'(exp_b.size()), 0);
    endtask

    task automatic push_r(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                          input logic [1:0] burst);
        int idx = int'(a[5 +: 9]);
        bit err = (burst != 2'b01);
        for (int b = 0; b <= int'(len); b++) begin
            exp_r.push_back('{id: id, data: err ? '0 : mdl[idx], resp: err ? 2'b10 : 2'b00,
                              last: b == int'(len), first: b == 0});
            idx = (idx + 1) % MD;
        end
    endtask

    task automatic rburst(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                          input logic [1:0] burst, input bit stall);
        int n = 0;
        int beat = 0;
        int st = 0;
        push_r(id, a, len, burst);
        rready = !stall;
        do_ar(id, a, len, burst);
        if (stall) begin
            while (beat <= int'(len) && n < 500) begin
                if (rvalid && !(beat == 1 && st < 5)) begin
                    rready = 1'b1; tick(); rready = 1'b0; beat++;
                end else begin
                    if (rvalid && beat == 1) st++;
                    tick();
                end
                n++;
            end
            rready = 1'b1;
        end
        while (exp_r.size() != 0 && n < 500) begin tick(); n++; end
        if (exp_r.size() != 0) chk("r_timeout", DW'(exp_r.size()), 0);
    endtask

    initial begin
        int n0;
        int n;
        i_reset = 1'b1;
        awvalid = 0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        wvalid = 0; wdata = '0; wstrb = '0; wlast = 0; bready = 1'b1;
        arvalid = 0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; rready = 1'b1;
        repeat (3) tick();
        i_reset = 1'b0;
        tick();

        // Basic 4-beat write and readback.
        wburst(8'd5, 42'h40, 8'd3, 2'b01, 4, 1, '1);
        chk("t1_bid_lit", DW'(last_bid), 5);
        chk("t1_bresp_lit", DW'(last_bresp), 0);
        n0 = r_beats_seen;
        rburst(8'd7, 42'h40, 8'd3, 2'b01, 1'b0);
        chk("t1_rbeats_lit", DW'(r_beats_seen - n0), 4);
        chk("t1_rid_lit", DW'(last_rid), 7);
        chk("t1_rlast_lit", DW'(last_rlast), 1);
        chk("t1_rdata_lit", last_rdata, {8{32'h00000103}});

        // Byte-strobe merge over an all-ones word.
        wburst(8'd1, 42'h100, 8'd0, 2'b01, 1, -1, '1);
        wburst(8'd2, 42'h100, 8'd0, 2'b01, 1, 0, 32'h0000000F);
        rburst(8'd3, 42'h100, 8'd0, 2'b01, 1'b0);
        chk("t2_strb_lit", last_rdata, {{224{1'b1}}, 32'h0});

        // Back-pressure on beat 2 of an 8-beat read.
        wburst(8'd4, 42'h200, 8'd7, 2'b01, 8, 2, '1);
        n0 = r_beats_seen;
        rburst(8'd8, 42'h200, 8'd7, 2'b01, 1'b1);
        chk("t3_rbeats_lit", DW'(r_beats_seen - n0), 8);
        chk("t3_lastdata_lit", last_rdata, {8{32'h00000207}});

        // Early wlast and WRAP read both report SLVERR.
        wburst(8'd6, 42'h300, 8'd3, 2'b01, 3, 3, '1);
        chk("t4_bresp_lit", DW'(last_bresp), 2);
        rburst(8'd9, 42'h300, 8'd1, 2'b10, 1'b0);
        tick(); tick();
        chk("t4_err_count_lit", DW'(o_err_count), 2);
        chk("t4_rdata_lit", last_rdata, '0);

        // Index wrap at the top of memory, and address aliasing.
        wburst(8'd3, 42'h3FE0, 8'd1, 2'b01, 2, 5, '1);
        rburst(8'd3, 42'h0, 8'd0, 2'b01, 1'b0);
        chk("t5_wrap_lit", last_rdata, {8{32'h00000501}});
        wburst(8'd4, 42'h4040, 8'd0, 2'b01, 1, 6, '1);
        rburst(8'd4, 42'h40, 8'd0, 2'b01, 1'b0);
        chk("t5_alias_lit", last_rdata, {8{32'h00000600}});

        // Reset during W_DATA abandons the burst.
        do_aw(8'd9, 42'h800, 8'd3, 2'b01);
        do_w(pat(7, 0), '1, 1'b0, 64, 1'b1);
        i_reset = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_w_reset_lit", DW'({awready, wready, bvalid, arready, rvalid}), 0);
        tick();
        i_reset = 1'b0;
        tick();

        // Reset during R_DATA abandons the read.
        push_r(8'd2, 42'h800, 8'd3, 2'b01);
        rready = 1'b0;
        do_ar(8'd2, 42'h800, 8'd3, 2'b01);
        n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        chk("t6_rvalid_seen", DW'(rvalid), 1);
        i_reset = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_r_reset_lit", DW'({awready, wready, bvalid, arready, rvalid}), 0);
        tick();
        i_reset = 1'b0;
        rready = 1'b1;
        tick();

        // Fresh traffic after reset completes normally.
        wburst(8'd9, 42'h800, 8'd1, 2'b01, 2, 8, '1);
        rburst(8'd9, 42'h800, 8'd1, 2'b01, 1'b0);
        chk("t6_fresh_lit", last_rdata, {8{32'h00000801}});

        repeat (4) tick();
        chk("exp_b_drained", DW'(exp_b.size()), 0);
        chk("exp_r_drained", DW'(exp_r.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
